// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups under a second-level
// group lookahead, followed by PIPE valid/ready register stages that collapse bubbles.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG = WIDTH / 4;
  // Stage payload layout: {cout, ovf, zero, sum}.
  localparam int unsigned RW = WIDTH + 3;

  logic [WIDTH-1:0] b_eff, g, p, c, s;
  logic             c0;
  logic [NG-1:0]    grp_g, grp_p;
  logic [NG:0]      grp_c;
  logic [RW-1:0]    res;

  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
    g     = a & b_eff;
    p     = a ^ b_eff;
  end

  always_comb begin : group_gp
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < int'(NG); k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Each group carry is a flat sum of products over lower groups, never a ripple.
  always_comb begin : group_carry
    logic acc;
    logic term;
    grp_c    = '0;
    grp_c[0] = c0;
    for (int k = 0; k < int'(NG); k++) begin
      acc = c0;
      for (int j = 0; j <= k; j++) acc = acc & grp_p[j];
      for (int j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      grp_c[k+1] = acc;
    end
  end

  always_comb begin : bit_carry
    logic cg;
    c = '0;
    for (int k = 0; k < int'(NG); k++) begin
      cg       = grp_c[k];
      c[4*k]   = cg;
      c[4*k+1] = g[4*k] | (p[4*k] & cg);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
    end
  end

  always_comb begin
    s   = p ^ c;
    res = {grp_c[NG], c[WIDTH-1] ^ grp_c[NG], ~|s, s};
  end

  // A stage may load when empty or when its occupant leaves this same cycle.
  logic [PIPE-1:0] v_vec;
  logic [PIPE-1:0] ld;
  logic [RW-1:0]   d_vec [PIPE];

  always_comb begin
    ld           = '0;
    ld[PIPE-1]   = !v_vec[PIPE-1] || out_ready;
    for (int i = int'(PIPE) - 2; i >= 0; i--) ld[i] = !v_vec[i] || ld[i+1];
  end

  for (genvar i = 0; i < int'(PIPE); i++) begin : g_stage
    logic          v_q;
    logic [RW-1:0] data_q;
    logic          v_in;
    logic [RW-1:0] d_in;

    if (i == 0) begin : g_first
      assign v_in = in_valid;
      assign d_in = res;
    end else begin : g_next
      assign v_in = v_vec[i-1];
      assign d_in = d_vec[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        data_q <= '0;
      end else if (ld[i]) begin
        v_q    <= v_in;
        data_q <= d_in;
      end
    end

    assign v_vec[i] = v_q;
    assign d_vec[i] = data_q;
  end

  assign in_ready               = ld[0];
  assign out_valid              = v_vec[PIPE-1];
  assign {cout, ovf, zero, sum} = d_vec[PIPE-1];

endmodule
